// File: rtl/radix4_booth_multiplier_seq_pkg.sv
// Shared definitions for the radix-4 Booth sequential multiplier.
// Holds the default width, Booth digit encoding and triplet decoder.
package radix4_booth_multiplier_seq_pkg;

   localparam int WIDTH_DEF = 32;

   typedef enum logic [2:0] {
      ZERO,
      POS1,
      POS2,
      NEG1,
      NEG2
   } booth_digit_t;

   function automatic booth_digit_t booth_digit(input logic [2:0] t);
      booth_digit_t d;
      case (t)
         3'b001,
         3'b010:  d = POS1;
         3'b011:  d = POS2;
         3'b100:  d = NEG2;
         3'b101,
         3'b110:  d = NEG1;
         default: d = ZERO;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/radix4_booth_multiplier_seq_if.sv
// Operand/result bundle of the Booth multiplier.
// Ports: load strobe, A/B operands (to block), OUT product (from block).
interface radix4_booth_multiplier_seq_if
   import radix4_booth_multiplier_seq_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
);

   logic                   load;
   logic [WIDTH-1:0]       A;
   logic [WIDTH-1:0]       B;
   logic [2*WIDTH-1:0]     OUT;

   modport master (
      output load,
      output A,
      output B,
      input  OUT
   );

   modport slave (
      input  load,
      input  A,
      input  B,
      output OUT
   );

endinterface

// File: rtl/radix4_booth_pp_gen.sv
// Radix-4 Booth partial product generator.
// Ports: triplet (multiplier bits), mcand (extended A), pp (0, +-M, +-2M).
module radix4_booth_pp_gen
   import radix4_booth_multiplier_seq_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [2:0]              triplet,
   input  logic signed [WIDTH+1:0] mcand,
   output logic signed [WIDTH+1:0] pp
);

   booth_digit_t digit;

   assign digit = booth_digit(triplet);

   // mcand carries two guard bits, so 2M and -2M cannot overflow
   always_comb begin
      pp = '0;
      unique case (digit)
         ZERO:    pp = '0;
         POS1:    pp = mcand;
         POS2:    pp = mcand <<< 1;
         NEG1:    pp = -mcand;
         NEG2:    pp = -(mcand <<< 1);
         default: pp = '0;
      endcase
   end

endmodule

// File: rtl/radix4_booth_multiplier_seq.sv
// Sequential signed multiplier, two multiplier bits per clock.
// Ports: clk, rst (sync active-low), bus (load/A/B in, OUT product out).
module radix4_booth_multiplier_seq
   import radix4_booth_multiplier_seq_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic clk,
   input  logic rst,
   radix4_booth_multiplier_seq_if.slave bus
);

   localparam int MW    = WIDTH + 2;
   localparam int AW    = 2*WIDTH + 2;
   localparam int STEPS = WIDTH / 2;
   localparam int CW    = $clog2(STEPS + 1);

   typedef enum logic {
      S_IDLE,
      S_BUSY
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic signed [MW-1:0]  mcand;
   logic signed [MW-1:0]  mcand_nxt;
   logic signed [WIDTH:0] mplier;
   logic signed [WIDTH:0] mplier_nxt;
   logic signed [AW-1:0]  acc;
   logic signed [AW-1:0]  acc_nxt;
   logic [CW-1:0]         cnt;
   logic [CW-1:0]         cnt_nxt;
   logic [2*WIDTH-1:0]    out_q;
   logic [2*WIDTH-1:0]    out_nxt;

   logic signed [MW-1:0]  pp;
   logic signed [AW-1:0]  pp_ext;
   logic signed [AW-1:0]  pp_sh;
   logic                  last;

   radix4_booth_pp_gen #(
      .WIDTH (WIDTH)
   ) u_pp_gen (
      .triplet (mplier[2:0]),
      .mcand   (mcand),
      .pp      (pp)
   );

   // Weight of step cnt is 4^cnt; bits shifted past acc are
   // modular overflow that cancels in the exact final sum.
   assign pp_ext = {{WIDTH{pp[MW-1]}}, pp};
   assign pp_sh  = pp_ext <<< {cnt, 1'b0};
   assign last   = (cnt == CW'(STEPS - 1));

   always_comb begin
      state_nxt  = state;
      mcand_nxt  = mcand;
      mplier_nxt = mplier;
      acc_nxt    = acc;
      cnt_nxt    = cnt;
      out_nxt    = out_q;
      if (bus.load) begin
         mcand_nxt  = {{2{bus.A[WIDTH-1]}}, bus.A};
         mplier_nxt = {bus.B, 1'b0};
         acc_nxt    = '0;
         cnt_nxt    = '0;
         state_nxt  = S_BUSY;
      end else if (state == S_BUSY) begin
         acc_nxt    = acc + pp_sh;
         mplier_nxt = mplier >>> 2;
         cnt_nxt    = cnt + 1'b1;
         if (last) begin
            out_nxt   = acc_nxt[2*WIDTH-1:0];
            state_nxt = S_IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= S_IDLE;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
         out_q  <= '0;
      end else begin
         state  <= state_nxt;
         mcand  <= mcand_nxt;
         mplier <= mplier_nxt;
         acc    <= acc_nxt;
         cnt    <= cnt_nxt;
         out_q  <= out_nxt;
      end
   end

   assign bus.OUT = out_q;

endmodule

// File: tb/tb_radix4_booth_multiplier_seq.sv
// Directed bench for the radix-4 Booth sequential multiplier.
// Drives the operand interface and checks OUT against hand values.
module tb_radix4_booth_multiplier_seq;

   localparam int W = 32;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   radix4_booth_multiplier_seq_if #(.WIDTH(W)) bus ();

   radix4_booth_multiplier_seq #(
      .WIDTH (W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int edges);
      bus.load = 1'b1;
      bus.A    = a;
      bus.B    = b;
      step(edges);
      bus.load = 1'b0;
      bus.A    = '0;
      bus.B    = '0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      step(1);
      checks++;
      if (bus.OUT !== 64'd0) begin
         errors++;
         $display("FAIL reset_out got %h want 0", bus.OUT);
      end
      rst = 1'b1;
      do_load(32'd12, -32'sd32, 2);
      step(16);
      checks++;
      if (bus.OUT !== -64'sd384) begin
         errors++;
         $display("FAIL reset_then_12x-32 got %h want %h", bus.OUT, -64'sd384);
      end
   endtask

   task automatic test_sweep();
      logic [W-1:0]   a_t [7];
      logic [W-1:0]   b_t [7];
      logic [2*W-1:0] e_t [7];
      a_t = '{32'd5, -32'sd51, -32'sd25, 32'd0, 32'd1, -32'sd12, 32'd13};
      b_t = '{32'd15, -32'sd4, -32'sd60, 32'd1234, 32'd12, 32'd72, 32'd20};
      e_t = '{64'd75, 64'd204, 64'd1500, 64'd0, 64'd12, -64'sd864, 64'd260};
      for (int i = 0; i < 7; i++) begin
         rst = 1'b0;
         step(1);
         rst = 1'b1;
         do_load(a_t[i], b_t[i], 1);
         step(18);
         checks++;
         if (bus.OUT !== e_t[i]) begin
            errors++;
            $display("FAIL sweep_%0d got %h want %h", i, bus.OUT, e_t[i]);
         end
      end
   endtask

   task automatic test_extremes();
      logic [W-1:0]   a_t [3];
      logic [W-1:0]   b_t [3];
      logic [2*W-1:0] e_t [3];
      a_t = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
      b_t = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
      e_t = '{64'h4000_0000_0000_0000, 64'hC000_0000_8000_0000, 64'd1};
      for (int i = 0; i < 3; i++) begin
         rst = 1'b0;
         step(1);
         rst = 1'b1;
         do_load(a_t[i], b_t[i], 1);
         step(16);
         checks++;
         if (bus.OUT !== e_t[i]) begin
            errors++;
            $display("FAIL extreme_%0d got %h want %h", i, bus.OUT, e_t[i]);
         end
      end
   endtask

   task automatic test_latency();
      rst = 1'b0;
      step(1);
      rst = 1'b1;
      do_load(32'd5, 32'd15, 1);
      step(16);
      do_load(32'd100, -32'sd3, 1);
      for (int i = 1; i <= 15; i++) begin
         step(1);
         checks++;
         if (bus.OUT !== 64'd75) begin
            errors++;
            $display("FAIL latency_hold_%0d got %h want %h", i, bus.OUT, 64'd75);
         end
      end
      step(1);
      checks++;
      if (bus.OUT !== -64'sd300) begin
         errors++;
         $display("FAIL latency_edge16 got %h want %h", bus.OUT, -64'sd300);
      end
   endtask

   task automatic test_restart();
      rst = 1'b0;
      step(1);
      rst = 1'b1;
      do_load(32'd7, 32'd9, 1);
      step(5);
      do_load(32'd3, -32'sd3, 1);
      for (int i = 1; i <= 15; i++) begin
         step(1);
         checks++;
         if (bus.OUT !== 64'd0) begin
            errors++;
            $display("FAIL restart_hold_%0d got %h want 0", i, bus.OUT);
         end
      end
      step(1);
      checks++;
      if (bus.OUT !== -64'sd9) begin
         errors++;
         $display("FAIL restart_result got %h want %h", bus.OUT, -64'sd9);
      end
   endtask

   task automatic test_reset_priority();
      do_load(32'd6, 32'd7, 1);
      step(4);
      rst      = 1'b0;
      bus.load = 1'b1;
      bus.A    = 32'd11;
      bus.B    = 32'd11;
      step(1);
      checks++;
      if (bus.OUT !== 64'd0) begin
         errors++;
         $display("FAIL rstprio_clear got %h want 0", bus.OUT);
      end
      rst      = 1'b1;
      bus.load = 1'b0;
      step(20);
      checks++;
      if (bus.OUT !== 64'd0) begin
         errors++;
         $display("FAIL rstprio_no_product got %h want 0", bus.OUT);
      end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      rst      = 1'b1;
      bus.load = 1'b0;
      bus.A    = '0;
      bus.B    = '0;
      #1;
      test_reset();
      test_sweep();
      test_extremes();
      test_latency();
      test_restart();
      test_reset_priority();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
